subtrator_serial: RTL and testbench

Bit-serial N-bit subtractor controller. It sequences a single `subtrator_completo` full-subtractor cell over the N bit positions of two operands, LSB first, and keeps the borrow in a flip-flop between cycles. It computes `a - b - bin` in N cycles using one 1-bit cell. It sits between the operand source (register file or bench) and any consumer that can tolerate multi-cycle latency in exchange for minimal area.

---
 rtl/subtrator_serial_if.sv | 24 ++
 rtl/subtrator_serial.sv | 126 ++++++++++++
 tb/tb_subtrator_serial.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/subtrator_serial_if.sv
// Operand/result bundle for the bit-serial subtractor.
// The master drives the start request and operands; the slave returns the result and status.
interface subtrator_serial_if #(
    parameter int N = 8
);
    logic         inicio;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         bin;
    logic [N-1:0] resultado;
    logic         borrow_out;
    logic         ocupado;
    logic         valido;

    modport master (
        output inicio, a, b, bin,
        input  resultado, borrow_out, ocupado, valido
    );

    modport slave (
        input  inicio, a, b, bin,
        output resultado, borrow_out, ocupado, valido
    );
endinterface

// File: rtl/subtrator_serial.sv
// Bit-serial N-bit subtractor: one full-subtractor cell walks the operands LSB first,
// with the borrow kept in a flop between cycles.
//
// state   | meaning
// OCIOSO  | idle, waiting for inicio
// CALCULA | processing one bit per cycle, cnt = bit index
// FIM     | result just registered, valido pulse, back to idle next edge

module subtrator_completo (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    output logic o_s,
    output logic o_cout
);
    assign o_s    = i_a ^ i_b ^ i_c;
    assign o_cout = (~i_a & i_b) | (~(i_a ^ i_b) & i_c);
endmodule

module subtrator_serial #(
    parameter int N = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    subtrator_serial_if.slave bus
);
    localparam int CNT_W = $clog2(N);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    typedef enum logic [1:0] {OCIOSO, CALCULA, FIM} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [N-1:0]     r_sa;
    logic [N-1:0]     r_sb;
    logic [N-1:0]     r_acc;
    logic [N-1:0]     r_resultado;
    logic             r_borrow;
    logic             r_borrow_out;
    logic             w_s;
    logic             w_cout;
    logic             w_ultimo;
    logic             w_ocupado;
    logic             w_valido;

    subtrator_completo u_cell (
        .i_a    (r_sa[0]),
        .i_b    (r_sb[0]),
        .i_c    (r_borrow),
        .o_s    (w_s),
        .o_cout (w_cout)
    );

    assign w_ultimo = (r_cnt == CNT_LAST);

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= OCIOSO;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        w_ocupado = 1'b0;
        w_valido  = 1'b0;
        case (r_state)
            OCIOSO: begin
                if (bus.inicio) w_next = CALCULA;
            end
            CALCULA: begin
                w_ocupado = 1'b1;
                if (w_ultimo) w_next = FIM;
            end
            FIM: begin
                w_ocupado = 1'b1;
                w_valido  = 1'b1;
                w_next    = OCIOSO;
            end
            default: w_next = OCIOSO;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt        <= '0;
            r_sa         <= '0;
            r_sb         <= '0;
            r_acc        <= '0;
            r_borrow     <= 1'b0;
            r_resultado  <= '0;
            r_borrow_out <= 1'b0;
        end else begin
            case (r_state)
                OCIOSO: begin
                    if (bus.inicio) begin
                        r_sa     <= bus.a;
                        r_sb     <= bus.b;
                        r_borrow <= bus.bin;
                        r_cnt    <= '0;
                        r_acc    <= '0;
                    end
                end
                CALCULA: begin
                    // difference bits enter at the MSB so bit 0 ends up at the LSB after N shifts
                    r_acc    <= {w_s, r_acc[N-1:1]};
                    r_sa     <= r_sa >> 1;
                    r_sb     <= r_sb >> 1;
                    r_borrow <= w_cout;
                    if (w_ultimo) begin
                        r_cnt        <= '0;
                        r_resultado  <= {w_s, r_acc[N-1:1]};
                        r_borrow_out <= w_cout;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.resultado  = r_resultado;
    assign bus.borrow_out = r_borrow_out;
    assign bus.ocupado    = w_ocupado;
    assign bus.valido     = w_valido;
endmodule

// File: tb/tb_subtrator_serial.sv
// Directed bench for subtrator_serial (N=8): vector table plus start-while-busy,
// mid-operation reset, back-to-back and reset-priority sequences.
module tb_subtrator_serial;
    localparam int N = 8;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    subtrator_serial_if #(.N(N)) bus ();

    subtrator_serial #(.N(N)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic       bin;
        logic [7:0] res;
        logic       bout;
    } vec_t;

    vec_t vecs [0:7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic bin,
                          input logic [7:0] er, input logic eb);
        logic [7:0] prev;
        logic       held;
        int         lat;
        @(negedge clk);
        prev       = bus.resultado;
        bus.a      = a;
        bus.b      = b;
        bus.bin    = bin;
        bus.inicio = 1'b1;
        @(negedge clk);
        bus.inicio = 1'b0;
        chk("ocupado_after_start", 32'(bus.ocupado), 1);
        lat  = 0;
        held = 1'b1;
        while (!bus.valido && lat < 20) begin
            if (bus.resultado !== prev) held = 1'b0;
            @(negedge clk);
            lat++;
        end
        chk("latency", 32'(lat), 8);
        chk("hold_during_calc", 32'(held), 1);
        chk("resultado", 32'(bus.resultado), 32'(er));
        chk("borrow_out", 32'(bus.borrow_out), 32'(eb));
        @(negedge clk);
        chk("valido_single", 32'(bus.valido), 0);
        chk("ocupado_after_fim", 32'(bus.ocupado), 0);
    endtask

    initial begin
        int lat, pulses, glitch, doubles, last_v, gap_bad;
        logic [7:0] r_res;
        logic       r_bo;
        logic       pv;

        vecs[0] = '{8'd200, 8'd55,  1'b0, 8'h91, 1'b0};
        vecs[1] = '{8'd5,   8'd10,  1'b0, 8'hFB, 1'b1};
        vecs[2] = '{8'h00,  8'h00,  1'b1, 8'hFF, 1'b1};
        vecs[3] = '{8'h80,  8'h7F,  1'b1, 8'h00, 1'b0};
        vecs[4] = '{8'hFF,  8'hFF,  1'b0, 8'h00, 1'b0};
        vecs[5] = '{8'h00,  8'hFF,  1'b0, 8'h01, 1'b1};
        vecs[6] = '{8'hAA,  8'h55,  1'b0, 8'h55, 1'b0};
        vecs[7] = '{8'h7F,  8'h80,  1'b0, 8'hFF, 1'b1};

        rst        = 1'b1;
        bus.inicio = 1'b0;
        bus.a      = '0;
        bus.b      = '0;
        bus.bin    = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_resultado", 32'(bus.resultado), 0);
        chk("rst_borrow_out", 32'(bus.borrow_out), 0);
        chk("rst_ocupado", 32'(bus.ocupado), 0);
        chk("rst_valido", 32'(bus.valido), 0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++)
            run_op(vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].res, vecs[i].bout);

        // start request arriving at E3 must be ignored
        @(negedge clk);
        bus.a = 8'd9; bus.b = 8'd3; bus.bin = 1'b0; bus.inicio = 1'b1;
        @(negedge clk);
        bus.inicio = 1'b0;
        lat = 0; pulses = 0; glitch = 0; r_res = '0; r_bo = 1'b1;
        for (int k = 0; k < 14; k++) begin
            if (bus.valido) begin
                pulses++;
                r_res = bus.resultado;
                r_bo  = bus.borrow_out;
            end
            if (lat <= 8 && !bus.ocupado) glitch = 1;
            if (lat == 2) begin
                bus.a = 8'd100; bus.b = 8'd1; bus.inicio = 1'b1;
            end else begin
                bus.inicio = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        chk("busy_pulses", 32'(pulses), 1);
        chk("busy_resultado", 32'(r_res), 6);
        chk("busy_borrow_out", 32'(r_bo), 0);
        chk("busy_ocupado_glitch", 32'(glitch), 0);

        // reset sampled at E4 aborts the operation
        @(negedge clk);
        bus.a = 8'd200; bus.b = 8'd55; bus.inicio = 1'b1;
        @(negedge clk);
        bus.inicio = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_resultado", 32'(bus.resultado), 0);
        chk("abort_borrow_out", 32'(bus.borrow_out), 0);
        chk("abort_ocupado", 32'(bus.ocupado), 0);
        chk("abort_valido", 32'(bus.valido), 0);
        rst = 1'b0;
        pulses = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (bus.valido) pulses++;
        end
        chk("abort_no_valido", 32'(pulses), 0);
        run_op(8'd1, 8'd1, 1'b0, 8'd0, 1'b0);

        // inicio held high: one operation every N+2 cycles
        @(negedge clk);
        bus.a = 8'd3; bus.b = 8'd1; bus.bin = 1'b0; bus.inicio = 1'b1;
        pulses = 0; doubles = 0; last_v = -1; gap_bad = 0; pv = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus.valido) begin
                if (pv) doubles++;
                if (last_v >= 0 && i - last_v != 10) gap_bad++;
                if (last_v < 0 && i != 8) gap_bad++;
                if (bus.resultado !== 8'd2) gap_bad++;
                last_v = i;
                pulses++;
            end
            pv = bus.valido;
        end
        bus.inicio = 1'b0;
        chk("b2b_pulses", 32'(pulses), 3);
        chk("b2b_spacing", 32'(gap_bad), 0);
        chk("b2b_no_double", 32'(doubles), 0);
        lat = 0;
        while (bus.ocupado && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("b2b_drain", 32'(bus.ocupado), 0);

        // reset wins over a simultaneous start
        @(negedge clk);
        rst = 1'b1; bus.inicio = 1'b1; bus.a = 8'd7; bus.b = 8'd1;
        @(negedge clk);
        chk("rstprio_ocupado", 32'(bus.ocupado), 0);
        chk("rstprio_valido", 32'(bus.valido), 0);
        @(negedge clk);
        chk("rstprio_ocupado_2", 32'(bus.ocupado), 0);
        rst = 1'b0; bus.inicio = 1'b0;
        repeat (3) @(negedge clk);
        chk("rstprio_idle", 32'(bus.ocupado), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
